// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle MIPS-subset controller.
// It holds the FSM state codes, the opcode/funct constants and the select-line
// encodings. The extender, the datapath muxes and the controller all import it.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] EOP_SIGN     = 2'b00;
  localparam logic [1:0] EOP_ZERO     = 2'b01;
  localparam logic [1:0] EOP_LUI      = 2'b10;
  localparam logic [1:0] EOP_SIGN_SH2 = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_JMP = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundle between the controller and the datapath.
//   master (controller): in  opcode, funct, zero[, mem_ready]
//                        out PCWr, IRWr, RegWr, MemWr, EOp, ALUOp, ALUSrcB,
//                            RegDst, WDSel, NPCOp, state
//   slave  (datapath)  : the same signals with directions reversed.
// Optional feature macro: MC_CTRL_MEM_WAIT_EN (adds mem_ready).
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
`ifdef MC_CTRL_MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       PCWr;
  logic       IRWr;
  logic       RegWr;
  logic       MemWr;
  logic [1:0] EOp;
  logic [2:0] ALUOp;
  logic       ALUSrcB;
  logic [1:0] RegDst;
  logic [1:0] WDSel;
  logic [1:0] NPCOp;
  logic [2:0] state;

  modport master (
    input  opcode, funct, zero,
`ifdef MC_CTRL_MEM_WAIT_EN
    input  mem_ready,
`endif
    output PCWr, IRWr, RegWr, MemWr, EOp, ALUOp, ALUSrcB, RegDst, WDSel,
           NPCOp, state
  );

  modport slave (
    output opcode, funct, zero,
`ifdef MC_CTRL_MEM_WAIT_EN
    output mem_ready,
`endif
    input  PCWr, IRWr, RegWr, MemWr, EOp, ALUOp, ALUSrcB, RegDst, WDSel,
           NPCOp, state
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational instruction classifier.
//   in  opcode[5:0], funct[5:0]  IR fields
//   out one-hot class flags plus is_valid (any supported instruction)
module mc_ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       is_r_add,
  output logic       is_r_sub,
  output logic       is_jr,
  output logic       is_ori,
  output logic       is_lui,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       is_j,
  output logic       is_jal,
  output logic       is_valid
);
  logic is_r;

  assign is_r     = (opcode == OP_RTYPE);
  assign is_r_add = is_r && (funct == FN_ADDU);
  assign is_r_sub = is_r && (funct == FN_SUBU);
  assign is_jr    = is_r && (funct == FN_JR);
  assign is_ori   = (opcode == OP_ORI);
  assign is_lui   = (opcode == OP_LUI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign is_valid = is_r_add | is_r_sub | is_jr | is_ori | is_lui | is_lw |
                    is_sw | is_beq | is_j | is_jal;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller (FETCH/DECODE/EXEC/MEM/WB).
//   clk   in  rising-edge clock
//   reset in  asynchronous, active-high
//   bus   mc_ctrl_if.master: IR fields and zero in, select/enable lines out
// Parameter MEM_WAIT_MAX: saturation limit of the MEM wait counter.
// Optional feature macro: MC_CTRL_MEM_WAIT_EN (MEM stalls on mem_ready).
//
// state    | meaning
// S_FETCH  | IR <= mem[PC], PC <= PC+4
// S_DECODE | classify; jumps complete here
// S_EXEC   | ALU operation; beq completes here
// S_MEM    | data memory access (lw/sw)
// S_WB     | register file write
module mc_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);
  localparam int unsigned WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  state_t state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic is_r_add, is_r_sub, is_jr, is_ori, is_lui, is_lw, is_sw;
  logic is_beq, is_j, is_jal, is_valid;
  logic mem_ready, wait_sat, mem_go;

  logic       pc_wr, ir_wr, reg_wr, mem_wr, alu_src_b;
  logic [1:0] eop, reg_dst, wd_sel, npc_op;
  logic [2:0] alu_op;

  mc_ctrl_decode u_decode (
    .opcode   (bus.opcode),
    .funct    (bus.funct),
    .is_r_add (is_r_add),
    .is_r_sub (is_r_sub),
    .is_jr    (is_jr),
    .is_ori   (is_ori),
    .is_lui   (is_lui),
    .is_lw    (is_lw),
    .is_sw    (is_sw),
    .is_beq   (is_beq),
    .is_j     (is_j),
    .is_jal   (is_jal),
    .is_valid (is_valid)
  );

  // Without the wait feature memory is always ready, so the counter
  // never leaves zero and MEM lasts exactly one cycle.
`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_ready = bus.mem_ready;
`else
  assign mem_ready = 1'b1;
`endif

  assign wait_sat = (wait_cnt_q == WAIT_W'(MEM_WAIT_MAX));
  assign mem_go   = mem_ready | wait_sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    eop        = EOP_SIGN;
    alu_op     = ALU_ADD;
    alu_src_b  = 1'b0;
    reg_dst    = RD_RT;
    wd_sel     = WD_ALU;
    npc_op     = NPC_PC4;

    case (state_q)
      S_FETCH: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        npc_op  = NPC_PC4;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        if (is_j) begin
          pc_wr   = 1'b1;
          npc_op  = NPC_JMP;
          state_d = S_FETCH;
        end else if (is_jal) begin
          pc_wr   = 1'b1;
          npc_op  = NPC_JMP;
          reg_wr  = 1'b1;
          reg_dst = RD_RA;
          wd_sel  = WD_PC;
          state_d = S_FETCH;
        end else if (is_jr) begin
          pc_wr   = 1'b1;
          npc_op  = NPC_JR;
          state_d = S_FETCH;
        end else if (is_valid) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_EXEC: begin
        state_d = S_WB;
        if (is_r_add) begin
          alu_op = ALU_ADD;
        end else if (is_r_sub) begin
          alu_op = ALU_SUB;
        end else if (is_ori) begin
          eop       = EOP_ZERO;
          alu_src_b = 1'b1;
          alu_op    = ALU_OR;
        end else if (is_lui) begin
          eop       = EOP_LUI;
          alu_src_b = 1'b1;
          alu_op    = ALU_ADD;
        end else if (is_lw || is_sw) begin
          eop       = EOP_SIGN;
          alu_src_b = 1'b1;
          alu_op    = ALU_ADD;
          state_d   = S_MEM;
        end else if (is_beq) begin
          eop     = EOP_SIGN_SH2;
          alu_op  = ALU_SUB;
          npc_op  = NPC_BR;
          pc_wr   = bus.zero;
          state_d = S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_MEM: begin
        // sw keeps MemWr up through every stalled cycle and the ready cycle.
        mem_wr = is_sw;
        if (mem_go) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_WB: begin
        reg_wr  = 1'b1;
        state_d = S_FETCH;
        if (is_r_add || is_r_sub) begin
          reg_dst = RD_RD;
          wd_sel  = WD_ALU;
        end else if (is_lw) begin
          reg_dst = RD_RT;
          wd_sel  = WD_MEM;
        end else begin
          reg_dst = RD_RT;
          wd_sel  = WD_ALU;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // FETCH is entered asynchronously on reset; gating keeps its enables
  // from firing while reset is still held.
  assign bus.PCWr    = pc_wr & ~reset;
  assign bus.IRWr    = ir_wr & ~reset;
  assign bus.RegWr   = reg_wr & ~reset;
  assign bus.MemWr   = mem_wr & ~reset;
  assign bus.EOp     = reset ? 2'b00 : eop;
  assign bus.ALUOp   = reset ? 3'b000 : alu_op;
  assign bus.ALUSrcB = alu_src_b & ~reset;
  assign bus.RegDst  = reset ? 2'b00 : reg_dst;
  assign bus.WDSel   = reset ? 2'b00 : wd_sel;
  assign bus.NPCOp   = reset ? 2'b00 : npc_op;
  assign bus.state   = state_q;
endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;
  typedef logic [18:0] word_t;

  typedef struct {
    logic [5:0]      op;
    logic [5:0]      fn;
    logic            zero;
    int              len;
    word_t [4:0]     exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  vec_t  vecs[$];
  word_t sb_q[$];

  mc_ctrl_if bus();

  mc_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic word_t w(input logic pc, input logic ir, input logic rw,
                              input logic mw, input logic [1:0] eop,
                              input logic [2:0] alu, input logic srcb,
                              input logic [1:0] rd, input logic [1:0] wd,
                              input logic [1:0] npc, input logic [2:0] st);
    return {pc, ir, rw, mw, eop, alu, srcb, rd, wd, npc, st};
  endfunction

  function automatic word_t dut_word();
    return {bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr, bus.EOp, bus.ALUOp,
            bus.ALUSrcB, bus.RegDst, bus.WDSel, bus.NPCOp, bus.state};
  endfunction

  task automatic check(input string name, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input int len, input word_t e0,
                         input word_t e1, input word_t e2, input word_t e3,
                         input word_t e4);
    vec_t v;
    v.op = op;
    v.fn = fn;
    v.zero = z;
    v.len = len;
    v.exp[0] = e0;
    v.exp[1] = e1;
    v.exp[2] = e2;
    v.exp[3] = e3;
    v.exp[4] = e4;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    word_t f_w, d0_w, wb_rd, wb_rt, ex_mem, z;
    word_t e;

    f_w    = w(1, 1, 0, 0, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 3'd0);
    d0_w   = w(0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 3'd1);
    wb_rd  = w(0, 0, 1, 0, 2'b00, 3'b000, 0, 2'b01, 2'b00, 2'b00, 3'd4);
    wb_rt  = w(0, 0, 1, 0, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 3'd4);
    ex_mem = w(0, 0, 0, 0, 2'b00, 3'b000, 1, 2'b00, 2'b00, 2'b00, 3'd2);
    z      = '0;

    // addu, subu, jr
    add_vec(6'b000000, 6'b100001, 1, 4, f_w, d0_w,
            w(0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 3'd2), wb_rd, z);
    add_vec(6'b000000, 6'b100011, 0, 4, f_w, d0_w,
            w(0, 0, 0, 0, 2'b00, 3'b001, 0, 2'b00, 2'b00, 2'b00, 3'd2), wb_rd, z);
    add_vec(6'b000000, 6'b001000, 0, 2, f_w,
            w(1, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b11, 3'd1), z, z, z);
    // ori then lui
    add_vec(6'b001101, 6'b000000, 0, 4, f_w, d0_w,
            w(0, 0, 0, 0, 2'b01, 3'b010, 1, 2'b00, 2'b00, 2'b00, 3'd2), wb_rt, z);
    add_vec(6'b001111, 6'b000000, 0, 4, f_w, d0_w,
            w(0, 0, 0, 0, 2'b10, 3'b000, 1, 2'b00, 2'b00, 2'b00, 3'd2), wb_rt, z);
    // lw, sw (funct bits of sw are junk and must be ignored)
    add_vec(6'b100011, 6'b000000, 0, 5, f_w, d0_w, ex_mem,
            w(0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 3'd3),
            w(0, 0, 1, 0, 2'b00, 3'b000, 0, 2'b00, 2'b01, 2'b00, 3'd4));
    add_vec(6'b101011, 6'b101010, 0, 4, f_w, d0_w, ex_mem,
            w(0, 0, 0, 1, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 3'd3), z);
    // beq taken / not taken
    add_vec(6'b000100, 6'b000000, 1, 3, f_w, d0_w,
            w(1, 0, 0, 0, 2'b11, 3'b001, 0, 2'b00, 2'b00, 2'b01, 3'd2), z, z);
    add_vec(6'b000100, 6'b000000, 0, 3, f_w, d0_w,
            w(0, 0, 0, 0, 2'b11, 3'b001, 0, 2'b00, 2'b00, 2'b01, 3'd2), z, z);
    // j, jal
    add_vec(6'b000010, 6'b000000, 0, 2, f_w,
            w(1, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b10, 3'd1), z, z, z);
    add_vec(6'b000011, 6'b000000, 0, 2, f_w,
            w(1, 0, 1, 0, 2'b00, 3'b000, 0, 2'b10, 2'b10, 2'b10, 3'd1), z, z, z);
    // nops: unknown opcode, all-zero word, unsupported R-type funct
    add_vec(6'b111111, 6'b111111, 1, 2, f_w, d0_w, z, z, z);
    add_vec(6'b000000, 6'b000000, 0, 2, f_w, d0_w, z, z, z);
    add_vec(6'b000000, 6'b100000, 0, 2, f_w, d0_w, z, z, z);

    reset = 1'b1;
    bus.opcode = 6'b000000;
    bus.funct = 6'b000000;
    bus.zero = 1'b0;
`ifdef MC_CTRL_MEM_WAIT_EN
    bus.mem_ready = 1'b1;
`endif
    #1;
    check("reset_outputs", dut_word(), z);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", dut_word(), z);
    reset = 1'b0;
    #1;
    check("post_reset_fetch", dut_word(), f_w);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.opcode = vecs[i].op;
      bus.funct = vecs[i].fn;
      bus.zero = vecs[i].zero;
      for (int c = 0; c < vecs[i].len; c++) sb_q.push_back(vecs[i].exp[c]);
      for (int c = 0; c < vecs[i].len; c++) begin
        @(negedge clk);
        e = sb_q.pop_front();
        check($sformatf("vec%0d_cyc%0d", i, c), dut_word(), e);
      end
      @(posedge clk);
      #1;
    end

`ifdef MC_CTRL_MEM_WAIT_EN
    // sw with memory not ready for three MEM cycles
    bus.opcode = 6'b101011;
    bus.funct = 6'b000000;
    bus.zero = 1'b0;
    @(negedge clk);
    check("wait_fetch", dut_word(), f_w);
    @(negedge clk);
    check("wait_decode", dut_word(), d0_w);
    @(negedge clk);
    check("wait_exec", dut_word(), ex_mem);
    #1 bus.mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("wait_mem%0d", c), dut_word(),
            w(0, 0, 0, 1, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 3'd3));
      if (c == 2) begin
        #1 bus.mem_ready = 1'b1;
      end
    end
    @(negedge clk);
    check("wait_exit", dut_word(), f_w);
    @(posedge clk);
    #1;
`endif

    // reset asserted in EXEC of an addu
    bus.opcode = 6'b000000;
    bus.funct = 6'b100001;
    bus.zero = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_exec", dut_word(),
          w(0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 2'b00, 2'b00, 3'd2));
    #1 reset = 1'b1;
    #1;
    check("mid_reset_now", dut_word(), z);
    @(posedge clk);
    #1;
    check("mid_reset_edge", dut_word(), z);
    reset = 1'b0;
    #1;
    check("mid_release_fetch", dut_word(), f_w);
    @(posedge clk);
    #1;
    check("mid_release_decode", dut_word(), d0_w);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
